// File: rtl/ahb_ram_slave_if.sv
// AHB-Lite bus bundle between an initiator and the on-chip RAM responder.
// hready_i is the shared bus HREADY; the interconnect (or bench) drives it.
interface ahb_ram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel_i;
  logic [ADDR_WIDTH-1:0] haddr_i;
  logic [1:0]            htrans_i;
  logic [2:0]            hsize_i;
  logic                  hwrite_i;
  logic                  hready_i;
  logic [DATA_WIDTH-1:0] hwdata_i;
  logic [DATA_WIDTH-1:0] hrdata_o;
  logic                  hready_o;
  logic                  hresp_o;

  modport master (
    output hsel_i, haddr_i, htrans_i, hsize_i, hwrite_i, hready_i, hwdata_i,
    input  hrdata_o, hready_o, hresp_o
  );

  modport slave (
    input  hsel_i, haddr_i, htrans_i, hsize_i, hwrite_i, hready_i, hwdata_i,
    output hrdata_o, hready_o, hresp_o
  );
endinterface

// File: rtl/ahb_ram_slave.sv
// AHB-Lite responder with an internal word-addressed RAM, byte-lane writes and ERROR response.
// Optional wait states per OKAY transfer are built only when AHB_RAM_WAIT_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready; completing cycle of an OKAY transfer when pend_q=1
// ST_WAIT | inserting wait states for an accepted OKAY transfer
// ST_ERR1 | first ERROR cycle (hready_o=0, hresp_o=1)
// ST_ERR2 | second ERROR cycle (hready_o=1, hresp_o=1), may accept
module ahb_ram_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_KB      = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 arst,
  ahb_ram_slave_if.slave       bus
);

  localparam int unsigned MEM_WORDS = MEM_KB * 256;
  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned NB        = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_KB * 1024);

`ifdef AHB_RAM_WAIT_EN
  localparam bit         WAIT_ON = (WAIT_CYCLES != 0);
  localparam logic [3:0] WAIT_TC = 4'(WAIT_CYCLES - 1);
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             hready_q, hready_d;
  logic             hresp_q, hresp_d;
  logic             pend_q, pend_d;
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;
  logic [1:0]       lane_q, lane_d;
  logic [IDX_W-1:0] idx_q, idx_d;
`ifdef AHB_RAM_WAIT_EN
  logic [3:0]       wait_cnt_q, wait_cnt_d;
`endif

  logic                  accept;
  logic                  addr_err;
  logic                  in_range;
  logic                  misalign;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  complete;
  logic [NB-1:0]         be;
  logic                  unused_htrans;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  assign unused_htrans = bus.htrans_i[0];

  // BASE_ADDR is size-aligned, so the word index is just the low offset bits
  always_comb begin
    accept   = bus.hsel_i & bus.hready_i & bus.htrans_i[1];
    offset   = bus.haddr_i - BASE_ADDR;
    in_range = (bus.haddr_i >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
    misalign = 1'b0;
    case (bus.hsize_i)
      3'd1:    misalign = bus.haddr_i[0];
      3'd2:    misalign = |bus.haddr_i[1:0];
      default: misalign = 1'b0;
    endcase
    addr_err = !in_range || (bus.hsize_i > 3'd2) || misalign;
  end

  always_comb begin
    state_d  = state_q;
    hready_d = hready_q;
    hresp_d  = hresp_q;
    pend_d   = pend_q;
    write_d  = write_q;
    size_d   = size_q;
    lane_d   = lane_q;
    idx_d    = idx_q;
`ifdef AHB_RAM_WAIT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d  = ST_IDLE;
        hready_d = 1'b1;
        hresp_d  = 1'b0;
        pend_d   = 1'b0;
        if (accept) begin
          write_d = bus.hwrite_i;
          size_d  = bus.hsize_i[1:0];
          lane_d  = bus.haddr_i[1:0];
          idx_d   = offset[IDX_W+1:2];
          if (addr_err) begin
            state_d  = ST_ERR1;
            hready_d = 1'b0;
            hresp_d  = 1'b1;
          end else begin
            pend_d = 1'b1;
`ifdef AHB_RAM_WAIT_EN
            if (WAIT_ON) begin
              state_d    = ST_WAIT;
              hready_d   = 1'b0;
              wait_cnt_d = '0;
            end
`endif
          end
        end
      end
      ST_ERR1: begin
        state_d  = ST_ERR2;
        hready_d = 1'b1;
        hresp_d  = 1'b1;
      end
`ifdef AHB_RAM_WAIT_EN
      ST_WAIT: begin
        hready_d = 1'b0;
        hresp_d  = 1'b0;
        if (wait_cnt_q == WAIT_TC) begin
          state_d    = ST_IDLE;
          hready_d   = 1'b1;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
`endif
      default: begin
        state_d  = ST_IDLE;
        hready_d = 1'b1;
        hresp_d  = 1'b0;
        pend_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q  <= ST_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      pend_q   <= 1'b0;
      write_q  <= 1'b0;
      size_q   <= '0;
      lane_q   <= '0;
      idx_q    <= '0;
`ifdef AHB_RAM_WAIT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      pend_q   <= pend_d;
      write_q  <= write_d;
      size_q   <= size_d;
      lane_q   <= lane_d;
      idx_q    <= idx_d;
`ifdef AHB_RAM_WAIT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Only OKAY transfers set pend_q, so ERROR phases never touch the array
  assign complete = pend_q & hready_q;

  always_comb begin
    be = '0;
    case (size_q)
      2'd0:    be[lane_q] = 1'b1;
      2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (complete && write_q) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[idx_q][8*b +: 8] <= bus.hwdata_i[8*b +: 8];
      end
    end
  end

  assign bus.hrdata_o = (complete && !write_q) ? mem_q[idx_q] : '0;
  assign bus.hready_o = hready_q;
  assign bus.hresp_o  = hresp_q;

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Directed bench for ahb_ram_slave with a queue scoreboard and a word-level RAM model.
// Build with AHB_RAM_WAIT_EN defined to also exercise the two-wait-state configuration.
module tb_ahb_ram_slave;

  localparam int MEM_KB      = 4;
  localparam int WAIT_CYCLES = 2;
`ifdef AHB_RAM_WAIT_EN
  localparam int WAIT_EFF = WAIT_CYCLES;
`else
  localparam int WAIT_EFF = 0;
`endif

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  ahb_ram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  assign bus.hready_i = bus.hready_o;

  ahb_ram_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_KB     (MEM_KB),
    .BASE_ADDR  (32'h0),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        resp;
    int          waits;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [0:1023];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_en = 1'b0;
  logic        dp_active;
  int          low_cnt = 0;
  logic [31:0] pend_wdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] addr, input logic [2:0] size);
    return (addr >= 32'(MEM_KB * 1024)) || (size > 3'd2) ||
           (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] lane,
                                        input logic [2:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    int l;
    r = old;
    l = int'(lane);
    case (size)
      3'd0:    r[8*l +: 8] = wdata[8*l +: 8];
      3'd1:    if (lane[1]) r[31:16] = wdata[31:16]; else r[15:0] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Tracks whether a data phase is in flight, from the bench's own view of accepts
  always @(posedge clk or negedge arst) begin
    if (!arst) dp_active <= 1'b0;
    else if (bus.hready_o === 1'b1) dp_active <= bus.hsel_i & bus.htrans_i[1];
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (dp_active) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $error("FAIL sb_empty: observed data phase expected none pending");
        end else if (bus.hready_o !== 1'b1) begin
          low_cnt++;
          check("wait_hresp", 32'(bus.hresp_o), 32'(exp_q[0].resp));
          check("wait_hrdata", bus.hrdata_o, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("dp_hrdata", bus.hrdata_o, e.rdata);
          check("dp_hresp", 32'(bus.hresp_o), 32'(e.resp));
          check("dp_waits", 32'(low_cnt), 32'(e.waits));
          low_cnt = 0;
        end
      end else begin
        check("idle_hready", 32'(bus.hready_o), 32'h1);
        check("idle_hresp", 32'(bus.hresp_o), 32'h0);
        check("idle_hrdata", bus.hrdata_o, 32'h0);
      end
    end
  end

  task automatic bus_step(input logic sel, input logic [1:0] trans, input logic wr,
                          input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    int   n;
    bit   err;
    exp_t e;
    @(negedge clk);
    bus.hwdata_i = pend_wdata;
    n = 0;
    while (bus.hready_o !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      n_checks++;
      n_errors++;
      $error("FAIL hready_timeout: observed hready_o=%b expected 1", bus.hready_o);
    end
    bus.hsel_i   = sel;
    bus.htrans_i = trans;
    bus.hwrite_i = wr;
    bus.haddr_i  = addr;
    bus.hsize_i  = size;
    if (sel && trans[1]) begin
      err     = is_err(addr, size);
      e.resp  = err;
      e.waits = err ? 1 : WAIT_EFF;
      e.rdata = (!err && !wr) ? model[addr[11:2]] : 32'h0;
      if (!err && wr) model[addr[11:2]] = merge(model[addr[11:2]], addr[1:0], size, wdata);
      exp_q.push_back(e);
      pend_wdata = wdata;
    end else begin
      pend_wdata = 32'h0;
    end
  endtask

  task automatic idle_step();
    bus_step(1'b1, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
`ifdef AHB_RAM_WAIT_EN
    logic [31:0] saved;
`endif
    arst         = 1'b1;
    bus.hsel_i   = 1'b0;
    bus.htrans_i = 2'b00;
    bus.hwrite_i = 1'b0;
    bus.haddr_i  = 32'h0;
    bus.hsize_i  = 3'd0;
    bus.hwdata_i = 32'h0;
    #2 arst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hready", 32'(bus.hready_o), 32'h1);
    check("rst_hresp", 32'(bus.hresp_o), 32'h0);
    check("rst_hrdata", bus.hrdata_o, 32'h0);
    arst   = 1'b1;
    mon_en = 1'b1;

    repeat (5) idle_step();

    bus_step(1, 2'b10, 1, 32'h10, 3'd2, 32'hDEADBEEF);
    bus_step(1, 2'b10, 0, 32'h10, 3'd2, 32'h0);

    bus_step(1, 2'b10, 1, 32'h10, 3'd2, 32'h11223344);
    bus_step(1, 2'b10, 1, 32'h13, 3'd0, 32'hAA000000);
    bus_step(1, 2'b10, 0, 32'h10, 3'd2, 32'h0);

    bus_step(1, 2'b10, 1, 32'h14, 3'd2, 32'h00000000);
    bus_step(1, 2'b10, 1, 32'h16, 3'd1, 32'hBEEF0000);
    bus_step(1, 2'b10, 0, 32'h14, 3'd2, 32'h0);

    idle_step();
    bus_step(1, 2'b10, 0, 32'h1000, 3'd2, 32'h0);
    idle_step();
    idle_step();

    bus_step(1, 2'b10, 1, 32'h20, 3'd2, 32'h5A5A5A5A);
    bus_step(1, 2'b10, 1, 32'h21, 3'd1, 32'h0000BEEF);
    bus_step(1, 2'b10, 0, 32'h20, 3'd2, 32'h0);
    bus_step(1, 2'b10, 1, 32'h20, 3'd3, 32'hFFFFFFFF);
    bus_step(1, 2'b10, 0, 32'h22, 3'd2, 32'h0);
    bus_step(1, 2'b01, 1, 32'h20, 3'd2, 32'hFFFFFFFF);
    bus_step(0, 2'b10, 1, 32'h20, 3'd2, 32'hFFFFFFFF);
    bus_step(1, 2'b11, 0, 32'h20, 3'd2, 32'h0);

    bus_step(1, 2'b10, 1, 32'hFFC, 3'd2, 32'hA5A50FF0);
    bus_step(1, 2'b11, 0, 32'hFFC, 3'd2, 32'h0);

    for (int i = 0; i < 16; i++) bus_step(1, 2'b10, 1, 32'h100 + 32'(4 * i), 3'd2, $urandom);
    for (int i = 0; i < 16; i++) begin
      sz = 3'($urandom_range(0, 1));
      a  = 32'h100 + 32'(4 * $urandom_range(0, 15));
      a  = a + ((sz == 3'd1) ? 32'(2 * $urandom_range(0, 1)) : 32'($urandom_range(0, 3)));
      bus_step(1, 2'b10, 1, a, sz, $urandom);
    end
    for (int i = 0; i < 16; i++) bus_step(1, 2'b11, 0, 32'h100 + 32'(4 * i), 3'd2, 32'h0);

`ifdef AHB_RAM_WAIT_EN
    bus_step(1, 2'b10, 1, 32'h30, 3'd2, 32'h01020304);
    bus_step(1, 2'b10, 0, 32'h30, 3'd2, 32'h0);
    repeat (2) idle_step();
    saved = model[12];
    bus_step(1, 2'b10, 1, 32'h30, 3'd2, 32'hCAFEF00D);
    model[12] = saved;
    mon_en    = 1'b0;
    exp_q.delete();
    @(negedge clk);
    bus.hwdata_i = 32'hCAFEF00D;
    bus.hsel_i   = 1'b0;
    bus.htrans_i = 2'b00;
    check("wait1_hready", 32'(bus.hready_o), 32'h0);
    @(negedge clk);
    check("wait2_hready", 32'(bus.hready_o), 32'h0);
    #1 arst = 1'b0;
    #1;
    check("midrst_hready", 32'(bus.hready_o), 32'h1);
    check("midrst_hresp", 32'(bus.hresp_o), 32'h0);
    @(negedge clk);
    arst       = 1'b1;
    low_cnt    = 0;
    pend_wdata = 32'h0;
    mon_en     = 1'b1;
    bus_step(1, 2'b10, 0, 32'h30, 3'd2, 32'h0);
`endif

    repeat (4) idle_step();
    check("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
